// File: rtl/rle_pkg.sv
// ---------------------------------------------------------------------------
// rle_pkg
// Shared types and constants for the history run-length encoder.
//   state_e     : encoder state (IDLE / RUN)
//   rle_rec_t   : {run_bit, len} record at the default length width
//   LEN_W_DEF   : default run-length field width
//   DEPTH_DEF   : default record FIFO depth
//   MAX_LEN_DEF : longest run chunk at the default width
// ---------------------------------------------------------------------------
package rle_pkg;

    localparam int LEN_W_DEF = 4;
    localparam int DEPTH_DEF = 4;

    localparam logic [LEN_W_DEF-1:0] MAX_LEN_DEF = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // "bit" is a keyword, so the value field is called run_bit.
    typedef struct packed {
        logic                 run_bit;
        logic [LEN_W_DEF-1:0] len;
    } rle_rec_t;

endpackage

// File: rtl/rle_fifo.sv
// ---------------------------------------------------------------------------
// rle_fifo
// Synchronous first-word-fall-through FIFO for encoder records.
//   clk, reset : clock, synchronous active-high reset
//   push, pop  : write / read requests (pop on empty is ignored)
//   data_in    : record to write
//   data_out   : head record while not empty, else the last popped record
//   empty,full : occupancy flags
//   level      : occupancy 0..DEPTH
// A push while full is accepted only when a pop frees the slot on the same
// edge; otherwise it is discarded and the parent reports the overflow.
// ---------------------------------------------------------------------------
module rle_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       data_out,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Showing the last popped record while empty keeps the outputs steady
    // instead of exposing a stale slot.
    assign data_out = empty ? last_q : mem_q[rd_ptr_q];
    assign level    = count_q;

endmodule

// File: rtl/history_rle_encoder.sv
// ---------------------------------------------------------------------------
// history_rle_encoder
// Run-length encodes the upstream history bit stream into {bit, length}
// records, queues them in a FWFT FIFO and cross-checks the upstream x/y
// "same as previous (two)" flags against the local run history.
//   clk, reset          : clock, synchronous active-high reset
//   a, x, y             : stream bit and upstream history flags
//   flush               : close the open run; the sample is ignored
//   out_ready           : consumer takes the head record
//   out_valid/bit/len   : head record
//   level               : FIFO occupancy
//   overflow, hist_err  : sticky error flags
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no run open; next non-flush sample starts one
// RUN   | run of cur_bit_q open, cnt_q samples in the current chunk
// ---------------------------------------------------------------------------
module history_rle_encoder
    import rle_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a,
    input  logic                   x,
    input  logic                   y,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic                   out_bit,
    output logic [LEN_W-1:0]       out_len,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   hist_err
);

    localparam logic [LEN_W-1:0] MAX_LEN = '1;
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_e           state_q, state_d;
    logic             cur_bit_q, cur_bit_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    // True run length saturated at 3; survives chunk splits so y stays valid.
    logic [1:0]       same_q, same_d;
    logic             overflow_q, overflow_d;
    logic             hist_err_q, hist_err_d;

    logic             push;
    logic             mism;
    logic             same_bit;
    logic             fifo_empty;
    logic             fifo_full;
    logic [LEN_W:0]   fifo_dout;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_bit_q  <= 1'b0;
            cnt_q      <= '0;
            same_q     <= '0;
            overflow_q <= 1'b0;
            hist_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_bit_q  <= cur_bit_d;
            cnt_q      <= cnt_d;
            same_q     <= same_d;
            overflow_q <= overflow_d;
            hist_err_q <= hist_err_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!flush) state_d = RUN;
            RUN:     if (flush)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Run counting, record pushes and history check
    always_comb begin
        cur_bit_d = cur_bit_q;
        cnt_d     = cnt_q;
        same_d    = same_q;
        push      = 1'b0;
        mism      = 1'b0;
        same_bit  = (a == cur_bit_q);

        case (state_q)
            IDLE: begin
                if (!flush) begin
                    cur_bit_d = a;
                    cnt_d     = ONE;
                    same_d    = 2'd1;
                end
            end
            RUN: begin
                if (flush) begin
                    push   = 1'b1;
                    cnt_d  = '0;
                    same_d = '0;
                end else begin
                    mism = (x != same_bit)
                         | (y != (same_bit & (same_q >= 2'd2)));
                    if (!same_bit) begin
                        push      = 1'b1;
                        cur_bit_d = a;
                        cnt_d     = ONE;
                        same_d    = 2'd1;
                    end else begin
                        if (same_q != 2'd3) begin
                            same_d = same_q + 2'd1;
                        end
                        // A full chunk is emitted and the run carries on.
                        if (cnt_q == MAX_LEN) begin
                            push  = 1'b1;
                            cnt_d = ONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Full FIFO accepts the push only if the consumer pops on this edge.
        overflow_d = overflow_q | (push & fifo_full & ~out_ready);
        hist_err_d = hist_err_q | mism;
    end

    rle_fifo #(
        .WIDTH (LEN_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (out_ready),
        .data_in  ({cur_bit_q, cnt_q}),
        .data_out (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (level)
    );

    assign out_valid = ~fifo_empty;
    assign out_bit   = fifo_dout[LEN_W];
    assign out_len   = fifo_dout[LEN_W-1:0];
    assign overflow  = overflow_q;
    assign hist_err  = hist_err_q;

endmodule

// File: tb/tb_history_rle_encoder.sv
module tb_history_rle_encoder;
    import rle_pkg::*;

    localparam int LEN_W = LEN_W_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int MAXL  = (1 << LEN_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   a = 1'b0;
    logic                   x = 1'b0;
    logic                   y = 1'b0;
    logic                   flush = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic                   out_bit;
    logic [LEN_W-1:0]       out_len;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic                   hist_err;

    always #5 clk = ~clk;

    history_rle_encoder #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .x         (x),
        .y         (y),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_len   (out_len),
        .level     (level),
        .overflow  (overflow),
        .hist_err  (hist_err)
    );

    int       n_pass  = 0;
    int       n_total = 0;
    rle_rec_t sb[$];
    rle_rec_t exp_r;
    bit       exp_ovf  = 1'b0;
    bit       exp_herr = 1'b0;
    bit       mon_en   = 1'b0;

    // Reference model: the open run as bit + true length (unbounded).
    bit       m_open = 1'b0;
    bit       m_bit  = 1'b0;
    int       m_len  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Closing chunk of a run of m_len samples after full chunks were emitted.
    function automatic rle_rec_t close_rec();
        rle_rec_t r;
        r.run_bit = m_bit;
        r.len     = LEN_W'(((m_len - 1) % MAXL) + 1);
        return r;
    endfunction

    // One clock: err 0 = correct x/y, 1 = wrong x, 2 = wrong y (only bites
    // when the sample is actually checked).
    task automatic step(input bit r, input bit ai, input bit fl, input bit rdy, input int err);
        bit       xi, yi, push, herr, drop;
        rle_rec_t rec;
        xi   = 1'($urandom);
        yi   = 1'($urandom);
        push = 1'b0;
        herr = 1'b0;
        rec  = '0;
        if (r) begin
            m_open = 1'b0;
        end else if (!m_open) begin
            if (!fl) begin
                m_open = 1'b1;
                m_bit  = ai;
                m_len  = 1;
            end
        end else if (fl) begin
            push   = 1'b1;
            rec    = close_rec();
            m_open = 1'b0;
        end else begin
            xi = (ai == m_bit);
            yi = xi && (m_len >= 2);
            if (err == 1) begin
                xi = ~xi; herr = 1'b1;
            end else if (err == 2) begin
                yi = ~yi; herr = 1'b1;
            end
            if (ai != m_bit) begin
                push  = 1'b1;
                rec   = close_rec();
                m_bit = ai;
                m_len = 1;
            end else begin
                if (m_len % MAXL == 0) begin
                    push        = 1'b1;
                    rec.run_bit = m_bit;
                    rec.len     = LEN_W'(MAXL);
                end
                m_len++;
            end
        end
        drop = push && (sb.size() == DEPTH) && !rdy;

        reset = r; a = ai; x = xi; y = yi; flush = fl; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            sb.delete();
            exp_ovf  = 1'b0;
            exp_herr = 1'b0;
        end else begin
            if (push) begin
                if (drop) exp_ovf = 1'b1;
                else sb.push_back(rec);
            end
            if (herr) exp_herr = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    endtask

    // Monitor: sampled mid-cycle, when inputs for the next edge are settled.
    always @(negedge clk) begin
        if (mon_en) begin
            check("level", int'(level), sb.size());
            check("out_valid", int'(out_valid), int'(sb.size() != 0));
            check("overflow", int'(overflow), int'(exp_ovf));
            check("hist_err", int'(hist_err), int'(exp_herr));
            if (out_valid && out_ready && !reset && sb.size() != 0) begin
                exp_r = sb.pop_front();
                check("out_bit", int'(out_bit), int'(exp_r.run_bit));
                check("out_len", int'(out_len), int'(exp_r.len));
            end
        end
    end

    initial begin
        bit la;
        do_reset();
        do_reset();
        check("rst_valid", int'(out_valid), 0);
        check("rst_bit", int'(out_bit), 0);
        check("rst_len", int'(out_len), 0);
        check("rst_level", int'(level), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_herr", int'(hist_err), 0);
        mon_en = 1'b1;

        // Basic run 1,1,1,0
        step(1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("basic_valid", int'(out_valid), 1);
        check("basic_bit", int'(out_bit), 1);
        check("basic_len", int'(out_len), 3);
        check("basic_herr", int'(hist_err), 0);
        drain(3);

        // Saturation: 16 ones then flush, consumer stalled
        do_reset();
        repeat (16) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("sat_level", int'(level), 1);
        check("sat_len", int'(out_len), 15);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("sat_level2", int'(level), 2);
        check("sat_herr", int'(hist_err), 0);
        drain(3);

        // Overflow: alternating bits, consumer stalled
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b0, 0);
        check("ovf_level", int'(level), 4);
        check("ovf_flag", int'(overflow), 1);
        drain(6);
        check("ovf_sticky", int'(overflow), 1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b0, 0);
        check("full_level", int'(level), 4);
        step(1'b0, 1'b1, 1'b0, 1'b1, 0);
        check("pp_level", int'(level), 4);
        check("pp_ovf", int'(overflow), 0);
        drain(6);

        // History mismatch: y wrong on third identical sample
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2);
        check("herr_y", int'(hist_err), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 0);
        check("herr_sticky", int'(hist_err), 1);
        // x claimed equal when the bit changed
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1);
        check("herr_x", int'(hist_err), 1);
        drain(3);

        // Reset mid-operation: 2 queued records plus open run of 5
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("mid_level", int'(level), 2);
        do_reset();
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_bit", int'(out_bit), 0);
        check("mid_rst_len", int'(out_len), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("mid_first_bit", int'(out_bit), 1);
        check("mid_first_len", int'(out_len), 1);
        drain(3);

        // Random traffic, clean history
        do_reset();
        la = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) >= 85) la = ~la;
            step(1'b0, la, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6), 0);
        end
        drain(DEPTH + 3);

        // Random traffic with occasional corrupted history flags
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) >= 80) la = ~la;
            step(1'b0, la, ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 199) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
        drain(DEPTH + 3);
        check("sb_empty", sb.size(), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/history_rle_encoder.md
Name: history_rle_encoder

Overview:
- Downstream consumer of the history state machine (one input bit `a` per clock, plus its `x` "same as previous" and `y` "same as previous two" flags).
- Run-length encodes the `a` stream into {bit, length} records.
- Buffers the records in a small FIFO and delivers them over a valid/ready interface.
- Cross-checks the upstream `x`/`y` flags against its own run count and raises a sticky error flag on any disagreement.

Parameters:
- LEN_W, 4: width of the run-length field. Maximum run chunk is 2^LEN_W-1.
- DEPTH, 4: FIFO depth in records (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- a  in  1  current stream bit, same cycle as the upstream FSM output.
- x  in  1  upstream flag: a equals the previous a.
- y  in  1  upstream flag: a equals the previous two a values.
- flush  in  1  close the open run now; the current sample is ignored.
- out_ready  in  1  consumer accepts the record this cycle.
- out_valid  out  1  record available.
- out_bit  out  1  bit value of the run.
- out_len  out  LEN_W  run length, range 1..2^LEN_W-1.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a record was dropped because the FIFO was full.
- hist_err  out  1  sticky: upstream x/y disagreed with the local history.

Behaviour:
- Reset (synchronous):
  - state=IDLE, cnt=0, cur_bit=0, FIFO emptied.
  - out_valid=0, out_bit=0, out_len=0, level=0, overflow=0, hist_err=0.
  - Any open run is discarded; no record is emitted for it.
- State machine:
  - IDLE: no run open.
    - flush=0: sample starts a run (cur_bit<=a, cnt<=1, go to RUN). x/y are not checked.
    - flush=1: stay in IDLE, no push.
  - RUN with flush=1: push {cur_bit,cnt}, go to IDLE. No x/y check; the sample is dropped.
  - RUN with a!=cur_bit: push {cur_bit,cnt}, then cur_bit<=a, cnt<=1.
  - RUN with a==cur_bit and cnt==2^LEN_W-1 (saturation): push {cur_bit,2^LEN_W-1}, then cnt<=1. The run continues as a new chunk.
  - RUN with a==cur_bit otherwise: cnt<=cnt+1.
- Run check: in RUN with flush=0, every cycle:
  - Expected x = (a==cur_bit).
  - Expected y = (a==cur_bit) & (cnt≥2), using the true run length, not the chunk count.
  - A separate 2-bit saturating "same count" counter tracks the true length across chunks.
  - Any mismatch sets hist_err on that edge. It stays set until reset.
- FIFO:
  - A push on edge t becomes visible at the output after edge t. Encoder-to-output latency is 1 cycle.
  - Pop occurs on an edge where out_valid & out_ready.
  - Simultaneous push and pop is legal at any level, including full: level is unchanged and no overflow.
  - Push when full with no pop: record dropped, overflow<=1 (sticky), FIFO contents unchanged.
  - Pop when empty: ignored. out_valid=0 implies out_bit/out_len hold their last value and carry no meaning.
  - Output is first-word-fall-through: out_bit/out_len show the head record whenever out_valid=1.
  - out_valid stays high and the head record stays stable until popped, even while out_ready=0.
  - Read and write pointers wrap modulo DEPTH; level is in 0..DEPTH.
- Reset asserted mid-run or mid-drain overrides flush, push and pop in the same cycle.

Decomposition:
- Package rle_pkg:
  - state typedef enum logic {IDLE, RUN}.
  - packed struct rle_rec_t {logic bit; logic [LEN_W-1:0] len} (LEN_W as a package localparam default, overridable through the module parameter).
  - Constant for maximum length.
- Sub-module rle_fifo: parameterised synchronous FWFT FIFO.
  - Inputs: push, pop, data_in. Outputs: data_out, empty, full, level.
  - Same clk/reset convention as the parent.
- The top level holds the encoder state machine, run counter, check logic and sticky flags.

Test Plan:
- Basic run, out_ready=1: a=1,1,1,0 with x=0,1,1,0 and y=0,0,1,0 → on the cycle after the 4th edge, out_valid=1, out_bit=1, out_len=3; hist_err=0.
- Saturation, LEN_W=4: 16 consecutive a=1 with correct x/y, then flush → records {1,15} then {1,1}; hist_err=0.
- Overflow: out_ready=0, alternating a=0,1,0,1,0,1 with correct x → level climbs to 4, the 5th closing push is dropped, overflow=1 and stays 1. Then out_ready=1 drains records {0,1},{1,1},{0,1},{1,1} in order.
- Full with simultaneous push and pop: level=4, out_ready=1 on the same edge as a run close → level stays 4, overflow stays 0, new record lands at the tail.
- History mismatch: a=0,0,0 with y=0 on the third sample → hist_err=1 after that edge, sticky. Separately, x=1 when a!=cur_bit → hist_err=1.
- Reset mid-operation: open run cnt=5 plus 2 queued records, reset pulsed for 1 cycle → next cycle level=0, out_valid=0, flags cleared, state IDLE. The first sample after reset starts cnt=1 regardless of x.
